// File: rtl/sd_block_seq_if.sv
// Bundle between the SD block sequencer and its command register, block buffer
// and SPI byte-exchange engine.
interface sd_block_seq_if;
  logic        start_rd;
  logic        start_wr;
  logic [31:0] blk_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [2:0]  err_code;
  logic [8:0]  buf_addr;
  logic        buf_we;
  logic [7:0]  buf_wdata;
  logic [7:0]  buf_rdata;
  logic        spi_cs_n;
  logic        xfer_req;
  logic [7:0]  xfer_tx;
  logic        xfer_ack;
  logic [7:0]  xfer_rx;

  modport master (
    input  start_rd, start_wr, blk_addr, buf_rdata, xfer_ack, xfer_rx,
    output busy, done, err, err_code, buf_addr, buf_we, buf_wdata,
           spi_cs_n, xfer_req, xfer_tx
  );

  modport slave (
    output start_rd, start_wr, blk_addr, buf_rdata, xfer_ack, xfer_rx,
    input  busy, done, err, err_code, buf_addr, buf_we, buf_wdata,
           spi_cs_n, xfer_req, xfer_tx
  );
endinterface

// File: rtl/sd_block_seq.sv
// Single-block CMD17/CMD24 sequencer for an initialised SDHC card over SPI,
// moving bytes between the card and a 512-byte block buffer.
module sd_block_seq #(
  parameter int RESP_POLLS  = 16,
  parameter int TOKEN_POLLS = 4096,
  parameter int BUSY_POLLS  = 65535,
  parameter int BLOCKSIZE   = 512
) (
  input logic            clk,
  input logic            rst,
  sd_block_seq_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_R1, S_TOKEN, S_RDATA, S_RCRC, S_GAP, S_WTOK,
    S_WWAIT, S_WSEND, S_WCRC, S_DRESP, S_BUSY, S_FIN_CS, S_FIN_X
  } state_e;

  state_e      r_state;
  logic        r_is_rd;
  logic [31:0] r_addr;
  logic [9:0]  r_cnt;
  logic [15:0] r_poll;
  logic        r_busy, r_done, r_err;
  logic [2:0]  r_code;
  logic [8:0]  r_buf_addr;
  logic        r_buf_we;
  logic [7:0]  r_buf_wdata;
  logic        r_cs_n, r_req;
  logic [7:0]  r_tx;

  logic [15:0] w_poll_nxt;
  logic        w_last_byte;
  logic [7:0]  w_tx_byte;

  assign w_poll_nxt  = r_poll + 16'd1;
  assign w_last_byte = (r_cnt == 10'(BLOCKSIZE - 1));

  // Byte to launch when the current state starts its next exchange.
  always_comb begin
    // NOTE: default first so every path assigns w_tx_byte and no latch is inferred.
    w_tx_byte = 8'hFF;
    case (r_state)
      S_CMD: begin
        case (r_cnt[2:0])
          3'd0:    w_tx_byte = r_is_rd ? 8'h51 : 8'h58;
          3'd1:    w_tx_byte = r_addr[31:24];
          3'd2:    w_tx_byte = r_addr[23:16];
          3'd3:    w_tx_byte = r_addr[15:8];
          3'd4:    w_tx_byte = r_addr[7:0];
          default: w_tx_byte = 8'hFF;
        endcase
      end
      S_WTOK:  w_tx_byte = 8'hFE;
      S_WSEND: w_tx_byte = bus.buf_rdata;
      default: w_tx_byte = 8'hFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_is_rd     <= 1'b0;
      r_addr      <= 32'd0;
      r_cnt       <= 10'd0;
      r_poll      <= 16'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= 3'd0;
      r_buf_addr  <= 9'd0;
      r_buf_we    <= 1'b0;
      r_buf_wdata <= 8'd0;
      r_cs_n      <= 1'b1;
      r_req       <= 1'b0;
      r_tx        <= 8'hFF;
    end else begin
      r_done   <= 1'b0;
      r_buf_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_rd || bus.start_wr) begin
            r_is_rd <= bus.start_rd;
            r_addr  <= bus.blk_addr;
            r_err   <= 1'b0;
            r_code  <= 3'd0;
            r_busy  <= 1'b1;
            r_cs_n  <= 1'b0;
            r_cnt   <= 10'd0;
            r_state <= S_CMD;
          end
        end
        S_WWAIT: r_state <= S_WSEND;
        S_FIN_CS: begin
          r_cs_n  <= 1'b1;
          r_state <= S_FIN_X;
        end
        default: begin
          if (!r_req) begin
            r_req <= 1'b1;
            r_tx  <= w_tx_byte;
          end else if (bus.xfer_ack) begin
            r_req <= 1'b0;
            case (r_state)
              S_CMD: begin
                if (r_cnt == 10'd5) begin
                  r_cnt   <= 10'd0;
                  r_poll  <= 16'd0;
                  r_state <= S_R1;
                end else r_cnt <= r_cnt + 10'd1;
              end
              S_R1: begin
                if (bus.xfer_rx != 8'hFF) begin
                  if (bus.xfer_rx != 8'h00) begin
                    r_err <= 1'b1; r_code <= 3'd2; r_state <= S_FIN_CS;
                  end else if (r_is_rd) begin
                    r_poll  <= 16'd0;
                    r_state <= S_TOKEN;
                  end else r_state <= S_GAP;
                end else if (w_poll_nxt == 16'(RESP_POLLS)) begin
                  r_err <= 1'b1; r_code <= 3'd1; r_state <= S_FIN_CS;
                end else r_poll <= w_poll_nxt;
              end
              S_TOKEN: begin
                if (bus.xfer_rx == 8'hFE) begin
                  r_cnt   <= 10'd0;
                  r_state <= S_RDATA;
                end else if (bus.xfer_rx != 8'hFF) begin
                  r_err <= 1'b1; r_code <= 3'd4; r_state <= S_FIN_CS;
                end else if (w_poll_nxt == 16'(TOKEN_POLLS)) begin
                  r_err <= 1'b1; r_code <= 3'd3; r_state <= S_FIN_CS;
                end else r_poll <= w_poll_nxt;
              end
              S_RDATA: begin
                r_buf_we    <= 1'b1;
                r_buf_addr  <= r_cnt[8:0];
                r_buf_wdata <= bus.xfer_rx;
                if (w_last_byte) begin
                  r_cnt   <= 10'd0;
                  r_state <= S_RCRC;
                end else r_cnt <= r_cnt + 10'd1;
              end
              S_RCRC: begin
                if (r_cnt == 10'd1) r_state <= S_FIN_CS;
                else r_cnt <= r_cnt + 10'd1;
              end
              S_GAP: r_state <= S_WTOK;
              S_WTOK: begin
                r_buf_addr <= 9'd0;
                r_cnt      <= 10'd0;
                r_state    <= S_WWAIT;
              end
              S_WSEND: begin
                if (w_last_byte) begin
                  r_cnt   <= 10'd0;
                  r_state <= S_WCRC;
                end else begin
                  r_cnt      <= r_cnt + 10'd1;
                  r_buf_addr <= r_cnt[8:0] + 9'd1;
                  r_state    <= S_WWAIT;
                end
              end
              S_WCRC: begin
                if (r_cnt == 10'd1) r_state <= S_DRESP;
                else r_cnt <= r_cnt + 10'd1;
              end
              S_DRESP: begin
                if ((bus.xfer_rx & 8'h1F) != 8'h05) begin
                  r_err <= 1'b1; r_code <= 3'd5; r_state <= S_FIN_CS;
                end else begin
                  r_poll  <= 16'd0;
                  r_state <= S_BUSY;
                end
              end
              S_BUSY: begin
                if (bus.xfer_rx == 8'hFF) r_state <= S_FIN_CS;
                else if (w_poll_nxt == 16'(BUSY_POLLS)) begin
                  r_err <= 1'b1; r_code <= 3'd6; r_state <= S_FIN_CS;
                end else r_poll <= w_poll_nxt;
              end
              S_FIN_X: begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_code  = r_code;
  assign bus.buf_addr  = r_buf_addr;
  assign bus.buf_we    = r_buf_we;
  assign bus.buf_wdata = r_buf_wdata;
  assign bus.spi_cs_n  = r_cs_n;
  assign bus.xfer_req  = r_req;
  assign bus.xfer_tx   = r_tx;

endmodule

// File: tb/tb_sd_block_seq.sv
// Scoreboard bench for sd_block_seq: scripted card model, registered buffer
// model, and monitors comparing exchanges, buffer writes and done status.
module tb_sd_block_seq;
  localparam int TB_BUSY_POLLS = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sd_block_seq_if sif();
  sd_block_seq #(.BUSY_POLLS(TB_BUSY_POLLS)) dut (.clk(clk), .rst(rst), .bus(sif));

  typedef enum {M_READ, M_WRITE, M_R1TO, M_TOKERR, M_WREJ, M_WBUSY} mode_e;
  mode_e mode = M_READ;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_tx   [$];   // {cs_n, tx}
  logic [31:0] exp_wr   [$];   // {addr, data}
  logic [31:0] exp_done [$];   // {err, err_code}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Block buffer with one-cycle registered read and a bench preload port.
  logic [7:0] mem [512];
  logic       pre_we = 1'b0;
  logic [8:0] pre_addr = 9'd0;
  logic [7:0] pre_data = 8'd0;
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (sif.buf_we) mem[sif.buf_addr] <= sif.buf_wdata;
    sif.buf_rdata <= mem[sif.buf_addr];
  end

  function automatic logic [7:0] card_rx(input mode_e m, input int k);
    case (m)
      M_READ: begin
        if (k == 6) return 8'h00;
        if (k == 10) return 8'hFE;
        if (k >= 11 && k <= 522) return 8'(k - 11);
        if (k == 523 || k == 524) return 8'h55;
        return 8'hFF;
      end
      M_TOKERR: begin
        if (k == 6) return 8'h00;
        if (k == 7) return 8'h08;
        return 8'hFF;
      end
      M_WRITE, M_WREJ, M_WBUSY: begin
        if (k == 6) return 8'h00;
        if (k == 523) return (m == M_WREJ) ? 8'h0B : 8'hE5;
        if (k >= 524 && m == M_WBUSY) return 8'h00;
        if (k >= 524 && k <= 528 && m == M_WRITE) return 8'h00;
        return 8'hFF;
      end
      default: return 8'hFF;
    endcase
  endfunction

  // Card: acks each request one half-cycle later; exchange index restarts at CS fall.
  int   k = 0;
  logic prev_cs = 1'b1;
  always @(negedge clk) begin
    if (rst) sif.xfer_ack = 1'b0;
    else if (sif.xfer_ack) sif.xfer_ack = 1'b0;
    else if (sif.xfer_req) begin
      sif.xfer_rx  = card_rx(mode, k);
      sif.xfer_ack = 1'b1;
      k++;
    end
    if (!sif.spi_cs_n && prev_cs) k = 0;
    prev_cs = sif.spi_cs_n;
  end

  // Monitors: pop the expected response whenever the DUT presents one.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) prev_req = 1'b0;
    else begin
      if (sif.xfer_req && !prev_req) begin
        e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 32'hDEAD;
        check("xfer_tx", {23'd0, sif.spi_cs_n, sif.xfer_tx}, e);
      end
      prev_req = sif.xfer_req;
      if (sif.buf_we) begin
        e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 32'hDEAD;
        check("buf_write", {15'd0, sif.buf_addr, sif.buf_wdata}, e);
      end
      if (sif.done) begin
        e = (exp_done.size() > 0) ? exp_done.pop_front() : 32'hDEAD;
        check("done_status", {28'd0, sif.err, sif.err_code}, e);
      end
    end
  end

  task automatic push_tx(input logic [7:0] b, input logic cs_n);
    exp_tx.push_back({23'd0, cs_n, b});
  endtask
  task automatic push_ff(input int n);
    for (int i = 0; i < n; i++) push_tx(8'hFF, 1'b0);
  endtask
  task automatic push_cmd(input logic [7:0] c, input logic [31:0] a);
    push_tx(c, 1'b0);
    push_tx(a[31:24], 1'b0);
    push_tx(a[23:16], 1'b0);
    push_tx(a[15:8], 1'b0);
    push_tx(a[7:0], 1'b0);
    push_tx(8'hFF, 1'b0);
  endtask
  task automatic push_read_ok(input logic [31:0] a);
    push_cmd(8'h51, a);
    push_ff(1);
    push_ff(4);
    push_ff(512);
    push_ff(2);
    push_tx(8'hFF, 1'b1);
    for (int i = 0; i < 512; i++) exp_wr.push_back({15'd0, 9'(i), 8'(i)});
  endtask
  task automatic push_write_data(input logic [31:0] a);
    push_cmd(8'h58, a);
    push_ff(1);
    push_ff(1);
    push_tx(8'hFE, 1'b0);
    for (int i = 0; i < 512; i++) push_tx(~8'(i), 1'b0);
    push_ff(2);
    push_ff(1);
  endtask

  task automatic preload_inv();
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 9'(i); pre_data = ~8'(i);
    end
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic pulse_start(input logic rd, input logic wr, input logic [31:0] a);
    @(negedge clk);
    sif.start_rd = rd; sif.start_wr = wr; sif.blk_addr = a;
    @(negedge clk);
    sif.start_rd = 1'b0; sif.start_wr = 1'b0;
  endtask

  task automatic wait_done(input logic [3:0] st);
    int n = 0;
    while (sif.done !== 1'b1 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, sif.done}, 32'd1);
    check("busy_low_at_done", {31'd0, sif.busy}, 32'd0);
    @(negedge clk);
    check("status_held", {28'd0, sif.err, sif.err_code}, {28'd0, st});
    check("queues_drained", exp_tx.size() + exp_wr.size() + exp_done.size(), 32'd0);
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] st);
    exp_done.push_back({28'd0, st});
    pulse_start(rd, wr, a);
    check("busy_after_start", {31'd0, sif.busy}, 32'd1);
    wait_done(st);
  endtask

  initial begin
    sif.start_rd = 1'b0;
    sif.start_wr = 1'b0;
    sif.blk_addr = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy",     {31'd0, sif.busy},     32'd0);
    check("rst_done",     {31'd0, sif.done},     32'd0);
    check("rst_err",      {28'd0, sif.err, sif.err_code}, 32'd0);
    check("rst_cs_n",     {31'd0, sif.spi_cs_n}, 32'd1);
    check("rst_req",      {31'd0, sif.xfer_req}, 32'd0);
    check("rst_tx",       {24'd0, sif.xfer_tx},  32'hFF);
    check("rst_buf",      {14'd0, sif.buf_we, sif.buf_addr, sif.buf_wdata}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mode = M_READ;
    push_read_ok(32'h1234);
    run_op(1'b1, 1'b0, 32'h1234, 4'h0);
    check("mem_300", {24'd0, mem[300]}, 32'h2C);

    preload_inv();
    mode = M_WRITE;
    push_write_data(32'hABCDEF01);
    push_ff(6);
    push_tx(8'hFF, 1'b1);
    run_op(1'b0, 1'b1, 32'hABCDEF01, 4'h0);

    mode = M_R1TO;
    push_cmd(8'h51, 32'h5);
    push_ff(16);
    push_tx(8'hFF, 1'b1);
    run_op(1'b1, 1'b0, 32'h5, {1'b1, 3'd1});

    mode = M_TOKERR;
    push_cmd(8'h51, 32'h6);
    push_ff(2);
    push_tx(8'hFF, 1'b1);
    run_op(1'b1, 1'b0, 32'h6, {1'b1, 3'd4});
    check("mem_unchanged", {24'd0, mem[7]}, 32'hF8);

    mode = M_WREJ;
    push_write_data(32'h10);
    push_tx(8'hFF, 1'b1);
    run_op(1'b0, 1'b1, 32'h10, {1'b1, 3'd5});

    mode = M_WBUSY;
    push_write_data(32'h20);
    push_ff(TB_BUSY_POLLS);
    push_tx(8'hFF, 1'b1);
    run_op(1'b0, 1'b1, 32'h20, {1'b1, 3'd6});

    // Simultaneous starts resolve to a read; a later write start is ignored.
    mode = M_READ;
    push_read_ok(32'h77);
    exp_done.push_back(32'd0);
    pulse_start(1'b1, 1'b1, 32'h77);
    repeat (40) @(negedge clk);
    pulse_start(1'b0, 1'b1, 32'hFFFF);
    wait_done(4'h0);

    // Reset in the middle of the data phase.
    push_read_ok(32'h99);
    pulse_start(1'b1, 1'b0, 32'h99);
    for (int n = 0; n < 3000 && k < 100; n++) @(negedge clk);
    check("reached_rdata", {31'd0, k >= 100}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", {31'd0, sif.spi_cs_n}, 32'd1);
    check("abort_req",  {31'd0, sif.xfer_req}, 32'd0);
    check("abort_busy", {31'd0, sif.busy},     32'd0);
    exp_tx.delete();
    exp_wr.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", {31'd0, sif.done | sif.busy}, 32'd0);

    push_read_ok(32'h1234);
    run_op(1'b1, 1'b0, 32'h1234, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sd_block_seq.md
Name: sd_block_seq

Overview:
- Sequences single-block SD-card transfers over SPI: CMD17 (read block) and CMD24 (write block) to an already-initialised, block-addressed (SDHC) card.
- Sits between the APB SD peripheral's command register, its 512-byte block buffer, and the SPI byte-exchange engine.
- Moves bytes between the card and the buffer, and reports done or error status.

Parameters:
- RESP_POLLS, 16, maximum 0xFF polls waiting for R1.
- TOKEN_POLLS, 4096, maximum polls waiting for the read start token.
- BUSY_POLLS, 65535, maximum polls waiting for write-busy release.
- BLOCKSIZE, 512, bytes per block; buffer address width is 9.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- start_rd  in  1  one-cycle pulse: read block blk_addr into the buffer.
- start_wr  in  1  one-cycle pulse: write the buffer to block blk_addr.
- blk_addr  in  32  card block number, sampled on the accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at the end of an operation (success or error).
- err  out  1  error flag of the last operation; valid with done, held until the next start.
- err_code  out  3  error code of the last operation; valid with done, held until the next start.
- buf_addr  out  9  block buffer address.
- buf_we  out  1  buffer write strobe.
- buf_wdata  out  8  buffer write data.
- buf_rdata  in  8  buffer read data, one-cycle registered latency after buf_addr.
- spi_cs_n  out  1  card chip select, active low.
- xfer_req  out  1  request one SPI byte exchange.
- xfer_tx  out  8  byte to send.
- xfer_ack  in  1  one-cycle pulse: exchange complete.
- xfer_rx  in  8  received byte, valid with xfer_ack.

Behaviour:
- Reset values: busy=0, done=0, err=0, err_code=0, spi_cs_n=1, xfer_req=0, xfer_tx=8'hFF, buf_we=0, buf_addr=0, buf_wdata=0. State = IDLE.
- Reset mid-operation aborts immediately to these values. No done pulse is issued.
- Exchange handshake:
  - xfer_req rises with xfer_tx stable; both are held until xfer_ack.
  - xfer_req is low in the cycle after xfer_ack and may reassert the cycle after that.
  - Each exchange below is one byte.
- IDLE:
  - Accepts start_rd or start_wr. If both are pulsed together, the read wins and the write is dropped.
  - Starts arriving while busy=1 are ignored.
  - On accept: latch blk_addr, clear err/err_code, set busy and spi_cs_n=0.
- CMD: six bytes, in order:
  - 0x40|idx (idx = 17 or 24)
  - blk_addr[31:24], [23:16], [15:8], [7:0]
  - CRC byte 0xFF
- R1: send 0xFF until xfer_rx != 0xFF.
  - No response within RESP_POLLS polls -> error 1.
  - Response != 0x00 -> error 2.
- Read path:
  - TOKEN: send 0xFF until xfer_rx != 0xFF.
    - 0xFE -> go to RDATA.
    - Any other non-0xFF byte -> error 4.
    - No token within TOKEN_POLLS polls -> error 3.
  - RDATA: 512 exchanges of 0xFF. Each received byte is written with buf_we=1 for exactly one cycle, buf_addr = byte index 0..511, in the cycle after its ack.
  - CRC: two exchanges of 0xFF; the received bytes are discarded.
  - Then FINISH.
- Write path:
  - GAP: one 0xFF.
  - TOKEN: send 0xFE.
  - WDATA: for index n = 0..511, drive buf_addr=n, wait one cycle, then send buf_rdata. buf_we stays 0 throughout.
  - CRC: two 0xFF.
  - DRESP: one 0xFF exchange. If (xfer_rx & 0x1F) != 0x05 -> error 5.
  - BUSY: send 0xFF until xfer_rx == 0xFF.
    - The DRESP byte does not count as a poll.
    - Not released within BUSY_POLLS polls -> error 6.
- Errors: any error goes to FINISH with err=1 and err_code set to the error number. Success leaves err=0 and err_code=0.
- FINISH:
  - spi_cs_n=1, then one trailing 0xFF exchange.
  - done pulses in the cycle after that exchange's ack; busy drops in the same cycle.
- Counters:
  - The byte counter is 10 bits and saturates nothing; the exit compare is at 511.
  - Poll counters are 16 bits. The compare is "polls issued == limit", checked after the ack of the limit-th poll.
- Steady-state throughput: minimum two cycles between exchanges, plus one extra buffer-read cycle per byte in WDATA.

Test Plan:
- Read, happy path: card model returns R1=0x00, three 0xFF, 0xFE, bytes i&0xFF, then CRC.
  -> CMD bytes 51 00 00 12 34 FF for blk_addr=0x1234; buffer holds 0x00..0xFF twice; done with err=0; spi_cs_n high before the trailing byte.
- Write, happy path: buffer preloaded with ~i; card returns DRESP 0xE5, then 0x00 ×5, then 0xFF.
  -> CMD byte 0x58; stream observed: FF, FE, 512 data bytes matching ~i, FF, FF; err=0.
- R1 timeout: card answers only 0xFF.
  -> exactly 16 polls after CMD; done with err=1, err_code=1; no buf_we asserted.
- Data error token: R1=0x00, then token 0x08.
  -> err_code=4; buffer unchanged.
- Write rejected: DRESP 0x0B -> err_code=5. Separately, busy never released -> err_code=6 after 65535 polls.
- Start collisions: start_rd and start_wr in the same cycle -> a read occurs. start_wr pulsed while busy -> ignored. rst asserted mid-RDATA -> spi_cs_n=1 and xfer_req=0 immediately, no done; a subsequent start works normally.
